// File: rtl/jt89_i2s_tx.sv
// JT89 PSG to I2S serializer: mono sample duplicated on left/right, one-deep holding register.
// Optional macro JT89_I2S_MUTE_EN: an empty slot sends silence instead of repeating the last word.
module jt89_i2s_tx #(
    parameter int bw   = 9,
    parameter int OUTW = 16,
    parameter int DIV  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic [bw+1:0] sound,
    output logic          sclk,
    output logic          lrclk,
    output logic          sdata,
    output logic          overrun
);
    localparam int SW = bw + 2;
    localparam int SH = OUTW - SW;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = 2 * OUTW;
    localparam int LW = $clog2(FW);

    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            sclk_q, sclk_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic            ovr_q, ovr_d;
    logic [LW-1:0]   slot_q, slot_d, slot_nxt;
    logic [OUTW-1:0] hold_q, hold_d;
    logic            pend_q, pend_d;
    logic [FW-1:0]   shr_q, shr_d;
    logic [OUTW-1:0] sext;
    logic [OUTW-1:0] word;
    logic            tick, fall, load;

    // Sign-extend to the word width, then left-justify.
    assign sext     = OUTW'($signed(sound)) << SH;
    assign tick     = (dcnt_q == DW'(DIV - 1));
    assign fall     = tick & sclk_q;
    assign load     = fall & (slot_q == '0);
    assign slot_nxt = (slot_q == LW'(FW - 1)) ? '0 : slot_q + 1'b1;

`ifdef JT89_I2S_MUTE_EN
    assign word = pend_q ? hold_q : '0;
`else
    logic [OUTW-1:0] last_q;
    assign word = pend_q ? hold_q : last_q;

    always_ff @(posedge clk) begin
        if (rst)       last_q <= '0;
        else if (load) last_q <= word;
    end
`endif

    always_comb begin
        dcnt_d  = tick ? '0 : dcnt_q + 1'b1;
        sclk_d  = tick ? ~sclk_q : sclk_q;
        slot_d  = slot_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        shr_d   = shr_q;
        hold_d  = hold_q;
        pend_d  = pend_q;
        // lrclk/sdata move only on the sclk falling edge so they are stable at the rise.
        if (fall) begin
            slot_d  = slot_nxt;
            lrclk_d = (slot_nxt >= LW'(OUTW));
            if (load) begin
                shr_d   = {word, word};
                sdata_d = word[OUTW-1];
                pend_d  = 1'b0;
            end else begin
                shr_d   = shr_q << 1;
                sdata_d = shr_q[FW-2];
            end
        end
        // A capture in the load cycle re-arms pend after the old hold was consumed.
        if (clk_en) begin
            hold_d = sext;
            pend_d = 1'b1;
        end
        ovr_d = clk_en & pend_q & ~load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q  <= '0;
            sclk_q  <= 1'b0;
            slot_q  <= '0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            shr_q   <= '0;
            hold_q  <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dcnt_q  <= dcnt_d;
            sclk_q  <= sclk_d;
            slot_q  <= slot_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            shr_q   <= shr_d;
            hold_q  <= hold_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sclk    = sclk_q;
    assign lrclk   = lrclk_q;
    assign sdata   = sdata_q;
    assign overrun = ovr_q;
endmodule

// File: tb/tb_jt89_i2s_tx.sv
// Bench for jt89_i2s_tx (bw=9, OUTW=16, DIV=2): I2S receiver, sample-path model and frame scoreboard.
module tb_jt89_i2s_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic [10:0] sound = '0;
  logic        sclk, lrclk, sdata, overrun;

  jt89_i2s_tx #(.bw(9), .OUTW(16), .DIV(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sound(sound),
    .sclk(sclk), .lrclk(lrclk), .sdata(sdata), .overrun(overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check / counters ----------------
  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- input capture at the active edge ----------------
  logic        rst_e = 1'b1;
  logic        en_e = 1'b0;
  logic [10:0] snd_e = '0;

  always @(posedge clk) begin
    rst_e = rst;
    en_e  = clk_en;
    snd_e = sound;
  end

  // ---------------- receiver, model and scoreboard ----------------
  logic [15:0] exp_q[$];
  int          b_slot = 0;
  logic        sclk_p = 0, lr_p = 0, sd_p = 0;
  logic [15:0] m_hold = '0, m_last = '0, m_word;
  logic        m_pend = 0, frame_act = 0;
  logic        fall_b, rise_b, load_b, exp_ov;
  logic [31:0] rx_sr = '0;
  logic [15:0] rx_left = '0, last_l = '0, last_r = '0;
  logic        last_rlsb = 0;
  int          frames = 0;
  int          ov_cnt = 0;

  always @(negedge clk) begin
    if (rst_e) begin
      check("rst_outs", {sclk, lrclk, sdata, overrun}, 4'b0000);
      b_slot = 0; m_hold = '0; m_last = '0; m_pend = 0; frame_act = 0;
      exp_q.delete();
      sclk_p = 0; lr_p = 0; sd_p = 0; rx_sr = '0;
    end else begin
      fall_b = sclk_p && !sclk;
      rise_b = !sclk_p && sclk;
      if (!fall_b) check("lr_sd_stable", {lrclk, sdata}, {lr_p, sd_p});
      load_b = 0;
      if (fall_b) begin
        b_slot = (b_slot == 31) ? 0 : b_slot + 1;
        load_b = (b_slot == 1);
      end
      exp_ov = en_e && m_pend && !load_b;
      if (load_b) begin
`ifdef JT89_I2S_MUTE_EN
        m_word = m_pend ? m_hold : 16'h0000;
`else
        m_word = m_pend ? m_hold : m_last;
`endif
        exp_q.push_back(m_word);
        m_last = m_word;
        m_pend = 0;
        frame_act = 1;
      end
      if (en_e) begin
        m_hold = {snd_e, 5'b00000};
        m_pend = 1;
      end
      check("overrun", overrun, exp_ov);
      if (overrun) ov_cnt++;
      if (rise_b) begin
        check("lrclk", lrclk, (b_slot >= 16));
        rx_sr = {rx_sr[30:0], sdata};
        if (b_slot == 16 && frame_act) rx_left = rx_sr[15:0];
        if (b_slot == 0 && frame_act) begin
          last_l    = rx_left;
          last_r    = rx_sr[15:0];
          last_rlsb = sdata;
          if (exp_q.size() == 0) begin
            check("frame_unexpected", 1, 0);
          end else begin
            check("frame_left", last_l, exp_q[0]);
            check("frame_right", last_r, exp_q[0]);
            void'(exp_q.pop_front());
          end
          frames++;
        end
      end
      sclk_p = sclk; lr_p = lrclk; sd_p = sdata;
    end
  end

  // ---------------- driver tasks (enter/exit at posedge+1) ----------------
  task automatic strobe(input logic [10:0] v);
    clk_en = 1'b1;
    sound  = v;
    @(posedge clk); #1;
    clk_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_slot(input int s);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (b_slot == s) break;
    end
    check("wait_slot_timeout", (k < 300), 1);
  endtask

  task automatic wait_frames(input int n);
    int target;
    int k;
    target = frames + n;
    for (k = 0; k < 300 * n; k++) begin
      if (frames >= target) break;
      @(posedge clk); #1;
    end
    check("wait_frames_timeout", (frames >= target), 1);
  endtask

  // Reset for ncyc cycles, optionally present a sample at release, then time the first edges.
  task automatic do_reset(input int ncyc, input bit with_smp, input logic [10:0] smp);
    int rise_c, fall_c, lr_c;
    rst = 1'b1;
    idle(ncyc);
    rst    = 1'b0;
    clk_en = with_smp;
    sound  = smp;
    rise_c = -1; fall_c = -1; lr_c = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      clk_en = 1'b0;
      if (c == 1) check("post_rst_outs", {sclk, lrclk, sdata, overrun}, 4'b0000);
      if (sclk && rise_c < 0) rise_c = c;
      if (!sclk && rise_c >= 0 && fall_c < 0) fall_c = c;
      if (lrclk && lr_c < 0) lr_c = c;
    end
    check("first_rise_cycle", rise_c, 2);
    check("first_fall_cycle", fall_c, 4);
    check("lrclk_rise_cycle", lr_c, 4 + 15 * 4);
  endtask

  // ---------------- stimulus ----------------
  int          ov0;
  logic [15:0] exp_w;

  initial begin
    // 1: reset and edge timing, nothing pending
    do_reset(5, 1'b0, 11'h000);

    // 2: positive full scale before the first load
    ov0 = ov_cnt;
    do_reset(5, 1'b1, 11'h3FF);
    wait_frames(1);
    check("pos_left", last_l, 16'h7FE0);
    check("pos_right", last_r, 16'h7FE0);
    check("pos_no_ovr", ov_cnt - ov0, 0);

    // 3: negative one, right LSB lands in slot 0 of the next frame
    wait_slot(5);
    strobe(11'h7FF);
    wait_frames(2);
    check("neg_left", last_l, 16'hFFE0);
    check("neg_right", last_r, 16'hFFE0);
    check("neg_rlsb", last_rlsb, 1'b0);

    // 4: two strobes ten cycles apart inside one frame
    wait_slot(3);
    ov0 = ov_cnt;
    strobe(11'h001);
    idle(9);
    strobe(11'h002);
    idle(2);
    check("ovr_once", ov_cnt - ov0, 1);
    wait_frames(2);
    check("ovr_word", last_l, 16'h0040);

    // 5: single sample then silence on the strobe line for three frames
    wait_slot(3);
    strobe(11'h100);
    wait_frames(1);
    for (int f = 1; f <= 3; f++) begin
      wait_frames(1);
      exp_w = 16'h2000;
`ifdef JT89_I2S_MUTE_EN
      if (f > 1) exp_w = 16'h0000;
`endif
      check($sformatf("repeat_f%0d", f), last_l, exp_w);
    end

    // 6: pending sample, then reset at slot 20; pend must be dropped
    wait_slot(18);
    strobe(11'h155);
    wait_slot(20);
    do_reset(1, 1'b0, 11'h000);
    wait_frames(1);
    check("midrst_word", last_l, 16'h0000);

    // randomized tail: strobes at random spacing, model and scoreboard do the checking
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(20, 200));
      strobe(11'($urandom_range(0, 2047)));
    end
    wait_frames(2);
    check("tail_queue_depth", (exp_q.size() <= 1), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
